// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, branch flush, data-memory wait freeze and timeout error.
// Optional macro PIPELINE_CTRL_STALL_CNT_EN adds the 32-bit stall_cycles_o counter.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ID_EX_MemRead_i,
  input  logic [4:0] IF_ID_RSaddr_i,
  input  logic [4:0] IF_ID_RTaddr_i,
  input  logic [4:0] ID_EX_RDaddr_i,
  input  logic       branch_taken_i,
  input  logic       mem_req_i,
  input  logic       mem_ack_i,
  output logic       PC_write_o,
  output logic       IF_ID_write_o,
  output logic       ID_EX_write_o,
  output logic       EX_MEM_write_o,
  output logic       ID_EX_bubble_o,
  output logic       IF_ID_flush_o,
  output logic       MEM_WB_bubble_o,
  output logic       err_o,
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  output logic [31:0] stall_cycles_o,
`endif
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e     state_q, state_d, eff_state;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_stall;
  logic       load_use;

  // While reset is held the outputs behave as in RUN, whatever the stored state.
  assign eff_state = rst_i ? ST_RUN : state_q;

  assign mem_stall = ((eff_state == ST_RUN) && mem_req_i && !mem_ack_i) ||
                     ((eff_state == ST_MEM_WAIT) && !mem_ack_i);

  assign load_use = ID_EX_MemRead_i && (ID_EX_RDaddr_i != 5'd0) &&
                    ((IF_ID_RSaddr_i == ID_EX_RDaddr_i) || (IF_ID_RTaddr_i == ID_EX_RDaddr_i));

  assign state_dbg_o = state_q;

  always_comb begin
    PC_write_o      = 1'b1;
    IF_ID_write_o   = 1'b1;
    ID_EX_write_o   = 1'b1;
    EX_MEM_write_o  = 1'b1;
    ID_EX_bubble_o  = 1'b0;
    IF_ID_flush_o   = 1'b0;
    MEM_WB_bubble_o = 1'b0;
    err_o           = 1'b0;
    if (eff_state == ST_ERR) begin
      PC_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      ID_EX_write_o   = 1'b0;
      EX_MEM_write_o  = 1'b0;
      ID_EX_bubble_o  = 1'b1;
      MEM_WB_bubble_o = 1'b1;
      err_o           = 1'b1;
    end else if (mem_stall) begin
      PC_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      ID_EX_write_o   = 1'b0;
      EX_MEM_write_o  = 1'b0;
      MEM_WB_bubble_o = 1'b1;
    end else if (load_use) begin
      PC_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      IF_ID_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        // An ack in the final allowed wait cycle still wins over the timeout.
        if (mem_ack_i) begin
          state_d = ST_RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == LAST_WAIT) state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
    end else if (!PC_write_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (TIMEOUT=4): directed hazard/memory scenarios then random traffic.
module tb_pipeline_ctrl;

  localparam int unsigned TO = 4;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  localparam int EW = 40;
`else
  localparam int EW = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic [4:0] rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic       br = 1'b0, req = 1'b0, ack = 1'b0;
  logic       pc_w, ifid_w, idex_w, exmem_w, idex_b, ifid_f, memwb_b, err;
  logic [1:0] state_dbg;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  pipeline_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .ID_EX_MemRead_i(mem_read),
    .IF_ID_RSaddr_i(rs), .IF_ID_RTaddr_i(rt), .ID_EX_RDaddr_i(rd),
    .branch_taken_i(br), .mem_req_i(req), .mem_ack_i(ack),
    .PC_write_o(pc_w), .IF_ID_write_o(ifid_w), .ID_EX_write_o(idex_w), .EX_MEM_write_o(exmem_w),
    .ID_EX_bubble_o(idex_b), .IF_ID_flush_o(ifid_f), .MEM_WB_bubble_o(memwb_b), .err_o(err),
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    .stall_cycles_o(stall_cycles),
`endif
    .state_dbg_o(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // Reference model: error flag, count of completed wait cycles (-1 when not waiting), stall total.
  bit      m_err = 1'b0;
  int      m_waited = -1;
  longint  m_stalls = 0;

  task automatic drive(input bit r, input bit mr, input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t, input bit b, input bit q, input bit a);
    logic [7:0]    o;
    logic [EW-1:0] e;
    bit            stall, lu, e_err;
    int            e_wait;
    @(posedge clk);
    #1;
    rst = r; mem_read = mr; rd = d; rs = s; rt = t; br = b; req = q; ack = a;
    cycle++;
    e_err  = r ? 1'b0 : m_err;
    e_wait = r ? -1 : m_waited;
    stall  = (e_wait < 0) ? (q && !a) : !a;
    lu     = mr && (d != 0) && (s == d || t == d);
    if (e_err)       o = 8'b0000_1011;
    else if (stall)  o = 8'b0000_0010;
    else if (lu)     o = 8'b0011_1000;
    else if (b)      o = 8'b1111_0100;
    else             o = 8'b1111_0000;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    e = {m_stalls[31:0], o};
`else
    e = o;
`endif
    exp_q.push_back(e);
    if (r) begin
      m_err = 1'b0; m_waited = -1; m_stalls = 0;
    end else begin
      if (!o[7] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (!m_err) begin
        if (m_waited < 0) begin
          if (q && !a) m_waited = 0;
        end else if (a) begin
          m_waited = -1;
        end else if (m_waited + 1 >= int'(TO)) begin
          m_err = 1'b1; m_waited = -1;
        end else begin
          m_waited++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e, act;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
`ifdef PIPELINE_CTRL_STALL_CNT_EN
      act = {stall_cycles, pc_w, ifid_w, idex_w, exmem_w, idex_b, ifid_f, memwb_b, err};
`else
      act = {pc_w, ifid_w, idex_w, exmem_w, idex_b, ifid_f, memwb_b, err};
`endif
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %h expected %h", cycle, act, e);
      end
    end
  end

  initial begin
    // reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use, then RD=0 must not stall
    drive(0, 1, 5, 5, 3, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 7, 2, 7, 0, 0, 0);
    idle(1);
    // branch alone, then branch with load-use, then branch re-evaluated
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    drive(0, 1, 9, 9, 1, 1, 0, 0);
    drive(0, 0, 0, 9, 1, 1, 0, 0);
    idle(1);
    // memory wait: ack low 3 cycles then high
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 1, 4, 4, 0, 0, 1, 1);
    idle(2);
    // timeout to ERR, inputs ignored, reset recovers
    for (int i = 0; i < 1 + int'(TO); i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 1, 3, 3, 3, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // boundary: ack in the last allowed wait cycle
    for (int i = 0; i < int'(TO); i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    // mid-operation reset during MEM_WAIT
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 39) == 0, 1'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
